// File: rtl/reg_file_dump_reader.sv
// rtl/reg_file_dump_reader.sv - walks a register range through one read port and streams index/value beats
module reg_file_dump_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] first_reg_i,
  input  logic [ADDR_WIDTH-1:0] last_reg_i,
  output logic [ADDR_WIDTH-1:0] rf_read_register_o,
  input  logic [DATA_WIDTH-1:0] rf_read_data_i,
  output logic                  dump_valid_o,
  input  logic                  dump_ready_i,
  output logic [DATA_WIDTH-1:0] dump_data_o,
  output logic [ADDR_WIDTH-1:0] dump_index_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  error_q, error_d;

  // State and datapath registers; reset drops any pending beat without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      last_q  <= '0;
      index_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      index_q <= index_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  // Next-state logic: ADDR presents the select for a full cycle, SEND holds the beat until accepted.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    index_d = index_q;
    data_d  = data_q;
    valid_d = valid_q;
    error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (first_reg_i <= last_reg_i) begin
            addr_d  = first_reg_i;
            last_d  = last_reg_i;
            state_d = ADDR;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ADDR: begin
        data_d  = rf_read_data_i;
        index_d = addr_q;
        valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (valid_q && dump_ready_i) begin
          valid_d = 1'b0;
          // Compare before incrementing so a range ending at the top index never wraps.
          if (addr_q == last_q) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = ADDR;
          end
        end
      end
      DONE: begin
        addr_d  = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The read select is the address register itself, so it carries no path from the inputs.
  assign rf_read_register_o = addr_q;
  assign dump_valid_o       = valid_q;
  assign dump_data_o        = data_q;
  assign dump_index_o       = index_q;
  assign busy_o             = (state_q == ADDR) || (state_q == SEND);
  assign done_o             = (state_q == DONE);
  assign error_o            = error_q;

endmodule

// File: tb/tb_reg_file_dump_reader.sv
// tb/tb_reg_file_dump_reader.sv - self-checking bench for reg_file_dump_reader
module tb_reg_file_dump_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [4:0]  first_reg_i;
  logic [4:0]  last_reg_i;
  logic [4:0]  rf_read_register_o;
  logic [31:0] rf_read_data_i;
  logic        dump_valid_o;
  logic        dump_ready_i;
  logic [31:0] dump_data_o;
  logic [4:0]  dump_index_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;

  logic [31:0] regs [32];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // Register file model: combinational read of the selected register.
  assign rf_read_data_i = regs[rf_read_register_o];

  reg_file_dump_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk                (clk),
    .reset              (reset),
    .start_i            (start_i),
    .first_reg_i        (first_reg_i),
    .last_reg_i         (last_reg_i),
    .rf_read_register_o (rf_read_register_o),
    .rf_read_data_i     (rf_read_data_i),
    .dump_valid_o       (dump_valid_o),
    .dump_ready_i       (dump_ready_i),
    .dump_data_o        (dump_data_o),
    .dump_index_o       (dump_index_o),
    .busy_o             (busy_o),
    .done_o             (done_o),
    .error_o            (error_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy"}, 64'(busy_o), 64'd0);
    check({tag, " valid"}, 64'(dump_valid_o), 64'd0);
    check({tag, " done"}, 64'(done_o), 64'd0);
  endtask

  // mode 0: ready always high (cycle-exact timing checked); 1: 4 stall cycles per beat; 2: random ready.
  // inject: pulse start_i with range 0..31 at cycle 3 while the dump is running.
  task automatic run_dump(input int first, input int last, input int mode, input bit inject);
    int          exp_idx[$];
    logic [31:0] exp_dat[$];
    int          cyc;
    int          beats;
    int          stall;
    bit          seen_done;
    logic        prev_valid;
    logic        prev_ready;
    logic [31:0] prev_data;
    logic [4:0]  prev_index;
    for (int i = first; i <= last; i++) begin
      exp_idx.push_back(i);
      exp_dat.push_back(regs[i]);
    end
    @(negedge clk);
    start_i     = 1'b1;
    first_reg_i = 5'(first);
    last_reg_i  = 5'(last);
    dump_ready_i = 1'b0;
    cyc = 0; beats = 0; stall = 0; seen_done = 1'b0;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_data = '0; prev_index = '0;
    while (!seen_done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start_i = 1'b0;
      if (inject && cyc == 3) begin
        start_i     = 1'b1;
        first_reg_i = 5'd0;
        last_reg_i  = 5'd31;
      end
      if (done_o) begin
        seen_done = 1'b1;
        check("done busy low", 64'(busy_o), 64'd0);
        check("done valid low", 64'(dump_valid_o), 64'd0);
        check("beats before done", 64'(exp_idx.size()), 64'd0);
        if (mode == 0) check("done cycle", 64'(cyc), 64'(2 * (last - first + 1) + 1));
      end else begin
        check("busy during dump", 64'(busy_o), 64'd1);
        if (prev_valid && !prev_ready) begin
          check("stall valid held", 64'(dump_valid_o), 64'd1);
          check("stall data held", 64'(dump_data_o), 64'(prev_data));
          check("stall index held", 64'(dump_index_o), 64'(prev_index));
        end
        if (dump_valid_o) begin
          case (mode)
            0: dump_ready_i = 1'b1;
            1: dump_ready_i = (stall >= 4);
            default: dump_ready_i = 1'($urandom_range(0, 1));
          endcase
          stall++;
          if (dump_ready_i) begin
            stall = 0;
            if (exp_idx.size() == 0) begin
              check("extra beat", 64'(dump_index_o), 64'h3f);
            end else begin
              check("beat index", 64'(dump_index_o), 64'(exp_idx.pop_front()));
              check("beat data", 64'(dump_data_o), 64'(exp_dat.pop_front()));
              if (mode == 0) check("beat cycle", 64'(cyc), 64'(2 * (beats + 1)));
            end
            beats++;
          end
        end else begin
          dump_ready_i = (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        end
      end
      prev_valid = dump_valid_o;
      prev_ready = dump_ready_i;
      prev_data  = dump_data_o;
      prev_index = dump_index_o;
    end
    check("dump finished in budget", 64'(seen_done), 64'd1);
    check("beat count", 64'(beats), 64'(last - first + 1));
    @(negedge clk);
    dump_ready_i = 1'b0;
    check("select back to 0", 64'(rf_read_register_o), 64'd0);
    for (int k = 0; k < 3; k++) begin
      check_idle("post dump");
      @(negedge clk);
    end
  endtask

  initial begin
    int f, l, n;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    regs[2]      = 32'h10010090;
    reset        = 1'b1;
    start_i      = 1'b0;
    first_reg_i  = '0;
    last_reg_i   = '0;
    dump_ready_i = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("reset select", 64'(rf_read_register_o), 64'd0);
    check("reset data", 64'(dump_data_o), 64'd0);
    check("reset index", 64'(dump_index_o), 64'd0);
    check("reset error", 64'(error_o), 64'd0);
    check_idle("reset");
    reset = 1'b0;

    // Full dump with ready tied high
    run_dump(0, 31, 0, 1'b0);

    // Preloaded single-register ranges, including the top index
    regs[10] = 32'hDEADBEEF;
    regs[31] = 32'h00000001;
    run_dump(10, 10, 0, 1'b0);
    run_dump(31, 31, 0, 1'b0);

    // Backpressure
    regs[5] = 32'h55555555; regs[6] = 32'h66666666; regs[7] = 32'h77777777;
    run_dump(5, 7, 1, 1'b0);

    // Illegal range
    @(negedge clk);
    start_i = 1'b1; first_reg_i = 5'd9; last_reg_i = 5'd3;
    @(negedge clk);
    start_i = 1'b0;
    check("illegal error pulse", 64'(error_o), 64'd1);
    check_idle("illegal");
    @(negedge clk);
    check("illegal error one cycle", 64'(error_o), 64'd0);
    check_idle("illegal after");

    // Start while busy
    run_dump(5, 7, 0, 1'b1);

    // Reset mid-dump during the SEND of index 12
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    @(negedge clk);
    start_i = 1'b1; first_reg_i = 5'd0; last_reg_i = 5'd31;
    n = 0;
    do begin
      @(negedge clk);
      start_i = 1'b0;
      dump_ready_i = !(dump_valid_o && dump_index_o == 5'd12);
      n++;
    end while (!(dump_valid_o && dump_index_o == 5'd12) && n < 200);
    check("reached index 12", 64'(dump_index_o), 64'd12);
    check("index 12 data", 64'(dump_data_o), 64'(regs[12]));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    dump_ready_i = 1'b0;
    check("midreset select", 64'(rf_read_register_o), 64'd0);
    check("midreset data", 64'(dump_data_o), 64'd0);
    check("midreset index", 64'(dump_index_o), 64'd0);
    check("midreset error", 64'(error_o), 64'd0);
    check_idle("midreset");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_idle("midreset after");
    end
    run_dump(0, 1, 0, 1'b0);

    // Randomized contents, ranges and backpressure
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      f = $urandom_range(0, 31);
      l = $urandom_range(f, (f + 8 > 31) ? 31 : f + 8);
      run_dump(f, l, 2, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
